// File: rtl/crono_ajuste_valor_pkg.sv
// -----------------------------------------------------------------------------
// crono_ajuste_valor_pkg
// Shared definitions for the chronometer value block: state codes, BCD field
// limits and the per-field BCD step helpers.
// -----------------------------------------------------------------------------
package crono_ajuste_valor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AJUSTE = 2'd1,
    CORRE  = 2'd2,
    ALARMA = 2'd3
  } estado_t;

  localparam logic [7:0] BCD_CERO        = 8'h00;
  localparam logic [7:0] BCD_UNO         = 8'h01;
  localparam logic [7:0] BCD_MAX_MIN_SEG = 8'h59;
  localparam logic [7:0] BCD_MAX_HORA    = 8'h23;
  localparam int         ALARMA_TICKS_DEF = 10;

  // +1 on a packed BCD field, wrapping from max to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == max_v) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // -1 on a packed BCD field, wrapping from 00 to max.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == 8'h00) begin
      r = max_v;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // True when exactly one of the three field selects is high.
  function automatic logic one_hot3(input logic a, input logic b, input logic c);
    logic r;
    case ({a, b, c})
      3'b100, 3'b010, 3'b001: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/crono_ajuste_valor_if.sv
// -----------------------------------------------------------------------------
// crono_ajuste_valor_if
// Field-select interface between the cursor selector (master) and the
// chronometer value block (slave).
//  sw_cronometro : adjust mode requested
//  a_cr_hora/min/seg : one-hot field select
//  sube / baja   : single-cycle increment / decrement pulses
//  arranque      : single-cycle start/pause/acknowledge pulse
// -----------------------------------------------------------------------------
interface crono_ajuste_valor_if;
  logic sw_cronometro;
  logic a_cr_hora;
  logic a_cr_min;
  logic a_cr_seg;
  logic sube;
  logic baja;
  logic arranque;

  modport master (
    output sw_cronometro, a_cr_hora, a_cr_min, a_cr_seg, sube, baja, arranque
  );

  modport slave (
    input sw_cronometro, a_cr_hora, a_cr_min, a_cr_seg, sube, baja, arranque
  );
endinterface

// File: rtl/crono_ajuste_valor_bcd_mod_cnt.sv
// -----------------------------------------------------------------------------
// crono_ajuste_valor_bcd_mod_cnt
// One packed-BCD field (00..MAX) with wrap-around step and load-to-max.
//  clk, rst  : clock, async active-low reset (value -> 00)
//  inc, dec  : step up / down (both together = hold)
//  load_max  : load MAX (highest priority)
//  valor     : registered BCD value
//  is_zero   : valor == 00
// -----------------------------------------------------------------------------
module crono_ajuste_valor_bcd_mod_cnt
  import crono_ajuste_valor_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load_max,
  output logic [7:0] valor,
  output logic       is_zero
);

  logic [7:0] valor_r;

  // Field register: load, step or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valor_r <= BCD_CERO;
    end else if (load_max) begin
      valor_r <= MAX;
    end else if (inc && !dec) begin
      valor_r <= bcd_inc(valor_r, MAX);
    end else if (dec && !inc) begin
      valor_r <= bcd_dec(valor_r, MAX);
    end else begin
      valor_r <= valor_r;
    end
  end

  assign valor   = valor_r;
  assign is_zero = (valor_r == BCD_CERO);

endmodule

// File: rtl/crono_ajuste_valor.sv
// -----------------------------------------------------------------------------
// crono_ajuste_valor
// Chronometer countdown value hh:mm:ss (packed BCD). In AJUSTE the selected
// field is stepped by sube/baja; in CORRE the value counts down on tick_1hz
// and reaching 00:00:00 enters ALARMA, where fin_crono stays high for
// ALARMA_TICKS ticks or until arranque.
//  clk, rst        : clock, async active-low reset
//  sel             : field-select interface (slave side)
//  tick_1hz        : one-cycle pulse per second
//  crono_hora/min/seg : BCD value
//  corriendo       : state is CORRE
//  fin_crono       : state is ALARMA
//  estado          : state code
// -----------------------------------------------------------------------------
module crono_ajuste_valor
  import crono_ajuste_valor_pkg::*;
#(
  parameter logic [7:0] HORA_MAX     = BCD_MAX_HORA,
  parameter logic [7:0] MIN_MAX      = BCD_MAX_MIN_SEG,
  parameter logic [7:0] SEG_MAX      = BCD_MAX_MIN_SEG,
  parameter int         ALARMA_TICKS = ALARMA_TICKS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  crono_ajuste_valor_if.slave   sel,
  input  logic                  tick_1hz,
  output logic [7:0]            crono_hora,
  output logic [7:0]            crono_min,
  output logic [7:0]            crono_seg,
  output logic                  corriendo,
  output logic                  fin_crono,
  output logic [1:0]            estado
);

  localparam int CNT_W = $clog2(ALARMA_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(ALARMA_TICKS - 1);

  estado_t          estado_r;
  estado_t          estado_nxt_s;
  logic             corriendo_r;
  logic             fin_r;
  logic [CNT_W-1:0] ticks_r;

  logic hora_inc_s, hora_dec_s;
  logic min_inc_s,  min_dec_s,  min_load_s;
  logic seg_inc_s,  seg_dec_s,  seg_load_s;
  logic hora_zero_s, min_zero_s, seg_zero_s;
  logic ajuste_ok_s, valor_cero_s, ultimo_seg_s;

  // A field edit needs exactly one field selected and exactly one direction.
  assign ajuste_ok_s  = one_hot3(sel.a_cr_hora, sel.a_cr_min, sel.a_cr_seg) &&
                        (sel.sube ^ sel.baja);
  assign valor_cero_s = hora_zero_s && min_zero_s && seg_zero_s;
  // The next countdown tick lands exactly on 00:00:00.
  assign ultimo_seg_s = hora_zero_s && min_zero_s && (crono_seg == BCD_UNO);

  // Next-state decision plus per-field steering (edits and borrow chain).
  always_comb begin
    estado_nxt_s = estado_r;
    hora_inc_s   = 1'b0;
    hora_dec_s   = 1'b0;
    min_inc_s    = 1'b0;
    min_dec_s    = 1'b0;
    min_load_s   = 1'b0;
    seg_inc_s    = 1'b0;
    seg_dec_s    = 1'b0;
    seg_load_s   = 1'b0;
    case (estado_r)
      IDLE: begin
        if (sel.sw_cronometro) begin
          estado_nxt_s = AJUSTE;
        end else if (sel.arranque && !valor_cero_s) begin
          estado_nxt_s = CORRE;
        end else begin
          estado_nxt_s = IDLE;
        end
      end
      AJUSTE: begin
        if (!sel.sw_cronometro) begin
          estado_nxt_s = IDLE;
        end else if (ajuste_ok_s) begin
          hora_inc_s = sel.a_cr_hora & sel.sube;
          hora_dec_s = sel.a_cr_hora & sel.baja;
          min_inc_s  = sel.a_cr_min  & sel.sube;
          min_dec_s  = sel.a_cr_min  & sel.baja;
          seg_inc_s  = sel.a_cr_seg  & sel.sube;
          seg_dec_s  = sel.a_cr_seg  & sel.baja;
        end else begin
          estado_nxt_s = AJUSTE;
        end
      end
      CORRE: begin
        if (sel.sw_cronometro) begin
          estado_nxt_s = AJUSTE;
        end else if (sel.arranque) begin
          estado_nxt_s = IDLE;
        end else if (tick_1hz) begin
          // Borrow chain: a zero field reloads its max and borrows from the next.
          seg_load_s = seg_zero_s;
          seg_dec_s  = !seg_zero_s;
          min_load_s = seg_zero_s && min_zero_s;
          min_dec_s  = seg_zero_s && !min_zero_s;
          hora_dec_s = seg_zero_s && min_zero_s;
          if (ultimo_seg_s) begin
            estado_nxt_s = ALARMA;
          end else begin
            estado_nxt_s = CORRE;
          end
        end else begin
          estado_nxt_s = CORRE;
        end
      end
      ALARMA: begin
        if (sel.sw_cronometro) begin
          estado_nxt_s = AJUSTE;
        end else if (sel.arranque) begin
          estado_nxt_s = IDLE;
        end else if (tick_1hz && (ticks_r == CNT_ULTIMO)) begin
          estado_nxt_s = IDLE;
        end else begin
          estado_nxt_s = ALARMA;
        end
      end
      default: begin
        estado_nxt_s = IDLE;
      end
    endcase
  end

  // State register, flag outputs decoded from the next state, alarm tick count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_r    <= IDLE;
      corriendo_r <= 1'b0;
      fin_r       <= 1'b0;
      ticks_r     <= '0;
    end else begin
      estado_r    <= estado_nxt_s;
      corriendo_r <= (estado_nxt_s == CORRE);
      fin_r       <= (estado_nxt_s == ALARMA);
      if (estado_nxt_s != ALARMA) begin
        ticks_r <= '0;
      end else if ((estado_r == ALARMA) && tick_1hz) begin
        ticks_r <= ticks_r + CNT_W'(1);
      end else begin
        ticks_r <= ticks_r;
      end
    end
  end

  crono_ajuste_valor_bcd_mod_cnt #(.MAX(HORA_MAX)) u_hora (
    .clk      (clk),
    .rst      (rst),
    .inc      (hora_inc_s),
    .dec      (hora_dec_s),
    .load_max (1'b0),
    .valor    (crono_hora),
    .is_zero  (hora_zero_s)
  );

  crono_ajuste_valor_bcd_mod_cnt #(.MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (min_inc_s),
    .dec      (min_dec_s),
    .load_max (min_load_s),
    .valor    (crono_min),
    .is_zero  (min_zero_s)
  );

  crono_ajuste_valor_bcd_mod_cnt #(.MAX(SEG_MAX)) u_seg (
    .clk      (clk),
    .rst      (rst),
    .inc      (seg_inc_s),
    .dec      (seg_dec_s),
    .load_max (seg_load_s),
    .valor    (crono_seg),
    .is_zero  (seg_zero_s)
  );

  assign corriendo = corriendo_r;
  assign fin_crono = fin_r;
  assign estado    = estado_r;

endmodule

// File: tb/tb_crono_ajuste_valor.sv
// -----------------------------------------------------------------------------
// tb_crono_ajuste_valor
// Directed scenarios followed by random stimulus; every cycle the DUT outputs
// are compared with a reference model that keeps the value as decimal fields
// and counts down through total seconds.
// -----------------------------------------------------------------------------
module tb_crono_ajuste_valor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [7:0] crono_hora, crono_min, crono_seg;
  logic       corriendo, fin_crono;
  logic [1:0] estado;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_st, m_h, m_m, m_s, m_acnt;

  crono_ajuste_valor_if sel_if ();

  crono_ajuste_valor dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel_if),
    .tick_1hz   (tick_1hz),
    .crono_hora (crono_hora),
    .crono_min  (crono_min),
    .crono_seg  (crono_seg),
    .corriendo  (corriendo),
    .fin_crono  (fin_crono),
    .estado     (estado)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int adj(input int v, input int mx, input logic up);
    if (up) return (v == mx) ? 0 : v + 1;
    else    return (v == 0) ? mx : v - 1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_acnt = 0;
  endtask

  task automatic model_step();
    int tot;
    int nsel;
    logic up, dn, arr, sw;
    up  = sel_if.sube; dn = sel_if.baja; arr = sel_if.arranque; sw = sel_if.sw_cronometro;
    nsel = int'(sel_if.a_cr_hora) + int'(sel_if.a_cr_min) + int'(sel_if.a_cr_seg);
    if (!rst) begin
      model_reset();
      return;
    end
    case (m_st)
      0: if (sw) m_st = 1;
         else if (arr && (m_h + m_m + m_s) != 0) m_st = 2;
      1: if (!sw) m_st = 0;
         else if ((up ^ dn) && nsel == 1) begin
           if (sel_if.a_cr_hora) m_h = adj(m_h, 23, up);
           if (sel_if.a_cr_min)  m_m = adj(m_m, 59, up);
           if (sel_if.a_cr_seg)  m_s = adj(m_s, 59, up);
         end
      2: if (sw) m_st = 1;
         else if (arr) m_st = 0;
         else if (tick_1hz) begin
           tot = m_h * 3600 + m_m * 60 + m_s - 1;
           m_h = tot / 3600; m_m = (tot / 60) % 60; m_s = tot % 60;
           if (tot == 0) begin m_st = 3; m_acnt = 0; end
         end
      3: if (sw) m_st = 1;
         else if (arr) m_st = 0;
         else if (tick_1hz) begin
           m_acnt++;
           if (m_acnt == 10) m_st = 0;
         end
      default: m_st = 0;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".hora"},  crono_hora, to_bcd(m_h));
    chk({tag, ".min"},   crono_min,  to_bcd(m_m));
    chk({tag, ".seg"},   crono_seg,  to_bcd(m_s));
    chk({tag, ".estado"}, {6'd0, estado}, 8'(m_st));
    chk({tag, ".corr"},  {7'd0, corriendo}, {7'd0, (m_st == 2)});
    chk({tag, ".fin"},   {7'd0, fin_crono}, {7'd0, (m_st == 3)});
  endtask

  // One clock with the given pulses held for that cycle
  task automatic cyc(input logic up, input logic dn, input logic arr, input logic tk);
    sel_if.sube = up; sel_if.baja = dn; sel_if.arranque = arr; tick_1hz = tk;
    @(posedge clk);
    model_step();
    #1;
    check_all("cyc");
    sel_if.sube = 1'b0; sel_if.baja = 1'b0; sel_if.arranque = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic pick(input logic h, input logic m, input logic s);
    sel_if.a_cr_hora = h; sel_if.a_cr_min = m; sel_if.a_cr_seg = s;
  endtask

  initial begin
    sel_if.sw_cronometro = 1'b0;
    pick(1'b0, 1'b0, 1'b0);
    sel_if.sube = 1'b0; sel_if.baja = 1'b0; sel_if.arranque = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Seconds wrap after 60 increments, minutes untouched
    sel_if.sw_cronometro = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("enter_ajuste", {6'd0, estado}, 8'd1);
    pick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("seg_wrap", crono_seg, 8'h00);
    chk("seg_wrap_min", crono_min, 8'h00);

    // Hours down from 00, minutes borrow 10 -> 09
    pick(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("hora_down_wrap", crono_hora, 8'h23);
    pick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("min_up_10", crono_min, 8'h10);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("min_borrow", crono_min, 8'h09);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sube_baja_hold", crono_min, 8'h09);
    pick(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("two_sel_hold", crono_min, 8'h09);

    // Build 00:01:00 and count it down to the alarm
    pick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    pick(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("hora_up_wrap", crono_hora, 8'h00);
    pick(1'b0, 1'b0, 1'b0);
    sel_if.sw_cronometro = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("start_corre", {7'd0, corriendo}, 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("first_tick_seg", crono_seg, 8'h59);
    chk("first_tick_min", crono_min, 8'h00);
    for (int i = 0; i < 59; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("alarma_estado", {6'd0, estado}, 8'd3);
    chk("alarma_fin", {7'd0, fin_crono}, 8'd1);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fin_after_9", {7'd0, fin_crono}, 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fin_after_10", {7'd0, fin_crono}, 8'd0);
    chk("idle_after_10", {6'd0, estado}, 8'd0);

    // Alarm acknowledged with arranque after 3 ticks
    sel_if.sw_cronometro = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    pick(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    pick(1'b0, 1'b0, 1'b0);
    sel_if.sw_cronometro = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("alarma2", {6'd0, estado}, 8'd3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ack_idle", {6'd0, estado}, 8'd0);

    // arranque at 00:00:00 in IDLE is ignored
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("arr_zero_idle", {6'd0, estado}, 8'd0);

    // arranque beats a same-cycle tick in CORRE
    sel_if.sw_cronometro = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    pick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    pick(1'b0, 1'b0, 1'b0);
    sel_if.sw_cronometro = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("arr_tick_estado", {6'd0, estado}, 8'd0);
    chk("arr_tick_seg", crono_seg, 8'h05);

    // Reset while running at 01:02:03
    sel_if.sw_cronometro = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    pick(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    pick(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    pick(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    pick(1'b0, 1'b0, 1'b0);
    sel_if.sw_cronometro = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_hora", crono_hora, 8'h01);
    chk("pre_rst_min", crono_min, 8'h02);
    chk("pre_rst_seg", crono_seg, 8'h03);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_estado", {6'd0, estado}, 8'd0);
    rst = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) sel_if.sw_cronometro = ~sel_if.sw_cronometro;
      if ($urandom_range(0, 3) == 0) begin
        sel_if.a_cr_hora = 1'($urandom_range(0, 1));
        sel_if.a_cr_min  = 1'($urandom_range(0, 1));
        sel_if.a_cr_seg  = 1'($urandom_range(0, 1));
      end
      cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
